// File: rtl/smg_scan_ctrl_if.sv
// Bundles the scan sequencer's control input, digit source and display outputs.
interface smg_scan_ctrl_if;
  logic        en;
  logic [23:0] digits_in;
  logic [5:0]  cur_state;
  logic [2:0]  digit_idx;
  logic [3:0]  digit_val;
  logic        tick;
  logic        blank;

  modport master (
    output en, digits_in,
    input  cur_state, digit_idx, digit_val, tick, blank
  );

  modport slave (
    input  en, digits_in,
    output cur_state, digit_idx, digit_val, tick, blank
  );
endinterface

// File: rtl/smg_scan_ctrl.sv
// Six-slot 1 ms scan sequencer for the seven-segment display, with aligned digit mux.
// Optional per-slot ghost blanking is enabled by defining SMG_GHOST_BLANK_EN.
module smg_scan_ctrl #(
  parameter logic [15:0] T1MS      = 16'd49999,
  parameter logic [15:0] BLANK_CYC = 16'd499
) (
  input logic           clk,
  input logic           rst,
  smg_scan_ctrl_if.slave bus
);

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    ST1  = 6'b000010,
    ST2  = 6'b000100,
    ST3  = 6'b001000,
    ST4  = 6'b010000,
    ST5  = 6'b100000
  } state_t;

  // Kept as a raw vector so an upset (non one-hot) value is representable and recoverable.
  logic [5:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  val_q, val_d;
  logic        tick_q, tick_d;
  logic        legal;
  state_t      nxt_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 16'd0;
      val_q   <= 4'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    legal     = 1'b1;
    nxt_state = IDLE;
    val_d     = 4'd0;

    case (state_q)
      IDLE:    nxt_state = ST1;
      ST1:     nxt_state = ST2;
      ST2:     nxt_state = ST3;
      ST3:     nxt_state = ST4;
      ST4:     nxt_state = ST5;
      ST5:     nxt_state = IDLE;
      default: legal     = 1'b0;
    endcase

    if (!legal) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      cnt_d   = 16'd0;
    end else if (bus.en) begin
      if (cnt_q == T1MS) begin
        cnt_d   = 16'd0;
        state_d = nxt_state;
        idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        tick_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    // Select by the slot being entered so digit_val lines up with cur_state.
    case (idx_d)
      3'd0:    val_d = bus.digits_in[23:20];
      3'd1:    val_d = bus.digits_in[19:16];
      3'd2:    val_d = bus.digits_in[15:12];
      3'd3:    val_d = bus.digits_in[11:8];
      3'd4:    val_d = bus.digits_in[7:4];
      3'd5:    val_d = bus.digits_in[3:0];
      default: val_d = 4'd0;
    endcase
  end

  assign bus.cur_state = state_q;
  assign bus.digit_idx = idx_q;
  assign bus.digit_val = val_q;
  assign bus.tick      = tick_q;

`ifdef SMG_GHOST_BLANK_EN
  assign bus.blank = (cnt_q < BLANK_CYC);
`else
  logic unused_blank_cfg;
  assign unused_blank_cfg = ^BLANK_CYC;
  assign bus.blank        = 1'b0;
`endif

endmodule

// File: doc/smg_scan_ctrl.md
# smg_scan_ctrl

Scan sequencer that drives the six-digit seven-segment display subsystem. It generates the one-hot `cur_state` slot sequence consumed by the digit-strobe scanner and advances one slot per 1 ms. In the same slot it selects the matching 4-bit digit value from a packed six-digit bus, so the segment decoder and the strobe logic stay aligned. It sits between game/score logic (digit source) and the display strobe/segment drivers.

## Interface
Parameters:
- `T1MS`, 16'd49999: slot length minus one, in clk cycles (50 MHz → 1 ms).
- `BLANK_CYC`, 16'd499: blanking cycles at the start of each slot; used only with `SMG_GHOST_BLANK_EN`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  1 = scanning runs; 0 = counter and slot freeze.
- `digits_in`  in  24  six BCD digits; digit 0 (first tube) = [23:20], digit 5 = [3:0].
- `cur_state`  out  6  one-hot slot: IDLE=000001, ST1=000010, ST2=000100, ST3=001000, ST4=010000, ST5=100000.
- `digit_idx`  out  3  binary index 0..5 of the current slot.
- `digit_val`  out  4  BCD value for the current slot.
- `tick`  out  1  one-cycle pulse on the cycle a new slot begins.
- `blank`  out  1  1 = segment drivers must output all-off.

## Operation
- 16-bit counter `cnt` counts 0..T1MS while `en`=1. When `cnt==T1MS` and `en`=1: `cnt`←0, slot advances, `tick`←1 for one cycle. `tick` is 0 on all other cycles.
- Slot order: IDLE→ST1→ST2→ST3→ST4→ST5→IDLE, with wrap-around. `digit_idx` tracks the slot: 0..5, wrapping 5→0.
- `en`=0: `cnt`, `cur_state`, and `digit_idx` hold; `tick`=0. `digit_val` keeps refreshing from `digits_in` for the held slot.
- `digit_val` is registered. Every cycle it loads the `digits_in` nibble selected by the next-cycle slot, so it always matches `cur_state` on the same cycle.
- Illegal `cur_state` (not one-hot, e.g. after an upset): on the next edge the block forces IDLE, `digit_idx`=0, `cnt`=0, and `tick`=0. This recovery does not depend on `en`.
- `digits_in` is not range-checked. Values 10–15 pass through unchanged, and the decoder handles them.
- Reset values: `cnt`=0, `cur_state`=000001, `digit_idx`=0, `digit_val`=0, `tick`=0. `blank`=1 with `SMG_GHOST_BLANK_EN` (if BLANK_CYC>0); `blank`=0 without it.
- Reset asserted mid-slot: all outputs take their reset values immediately (asynchronous). The first slot after release is a full T1MS+1 cycles long.

## Timing
- Slot period: exactly T1MS+1 cycles while `en`=1. Full six-slot frame: 6×(T1MS+1) cycles.
- On the edge where `cnt`=T1MS: `cur_state`, `digit_idx`, and `digit_val` update together, and `tick` rises in that same cycle.
- `digits_in` → `digit_val` latency: 1 cycle.
- With `en` low for N cycles, the current slot is stretched by N cycles. A counted-but-frozen terminal value does not produce a `tick` until `en` returns high.
- `blank` is a combinational compare on the registered `cnt`: `blank` = (`cnt` < BLANK_CYC).

## Configuration
- `SMG_GHOST_BLANK_EN` defined: `blank`=1 for the first BLANK_CYC cycles of every slot (`cnt`=0..BLANK_CYC-1), then 0 for the rest of the slot. This suppresses ghosting while the strobes switch.
- `SMG_GHOST_BLANK_EN` not defined: `blank` is tied to 0, and the BLANK_CYC compare logic is not synthesized.

## Test plan
- Reset: assert `rst` → `cur_state`=000001, `digit_idx`=0, `digit_val`=0, `tick`=0. `blank`=1 with the macro, 0 without.
- Rotation: `en`=1, defaults → `tick` pulses every 50000 cycles. `cur_state` walks 000001→000010→…→100000→000001, and `digit_idx` walks 0..5→0.
- Digit mux: `digits_in`=24'h123456 → `digit_val` reads 1,2,3,4,5,6 in IDLE..ST5. Changing `digits_in` to 24'h9A0000 during IDLE gives `digit_val`=9 one cycle later.
- Enable hold: drop `en` at `cnt`=100 for 1000 cycles → no `tick`, outputs frozen. The next `tick` comes 49900 cycles after `en` returns high.
- Illegal-state recovery: force `cur_state`=6'b000011 for one cycle, then release → next edge gives `cur_state`=000001, `digit_idx`=0, `cnt`=0.
- Blanking (with macro): `blank`=1 for cycles 0..498 of each slot and 0 for 499..49999. Pulse `rst` mid-slot → `cnt`=0, `blank`=1, and the next `tick` comes 50000 cycles after release.
